parking_lot_tracker: RTL and testbench
======================================

# parking_lot_tracker

Consumes the two debounced optical-sensor levels (outer sensor `a`, inner sensor `b`) from the debounce stage. Decodes the ordered blocking pattern of a car passing the gate into single-cycle `enter`/`exit` events, and keeps a saturating occupancy count with full/empty flags. Sits directly downstream of the two sensor debouncers and feeds the display/LED logic.

## Interface
- `CNT_W`, default 4: occupancy counter width.
- `CAPACITY`, default 15: lot capacity. Must satisfy 1 ≤ `CAPACITY` ≤ 2^`CNT_W`−1.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a`  in  1  debounced outer sensor, 1 = beam blocked; synchronous to `clk`.
- `b`  in  1  debounced inner sensor, 1 = beam blocked; synchronous to `clk`.
- `enter`  out  1  one-cycle pulse on a completed entry.
- `exit`  out  1  one-cycle pulse on a completed exit.
- `err`  out  1  one-cycle pulse on an illegal sensor transition.
- `count`  out  `CNT_W`  current occupancy.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `err_cnt`  out  8  saturating illegal-sequence count; present only with `LOT_ERR_CNT_EN`.

## Operation
- Inputs are already synchronous and debounced; there is no internal synchronizer.
- FSM states and their `{a,b}` patterns:
  - IDLE: 00.
  - EN1: 10. EN2: 11. EN3: 01.
  - EX1: 01. EX2: 11. EX3: 10.
  - WAIT_CLR: waiting for 00 after an error.
- Forward path, entry: IDLE→EN1→EN2→EN3→IDLE.
- Forward path, exit: IDLE→EX1→EX2→EX3→IDLE.
- From IDLE: 10→EN1; 01→EX1; 11→WAIT_CLR with `err`.
- Backing out is legal and emits no event. Each ENk/EXk returns to the previous state when the pattern of that state reappears (e.g. EN2 seeing 10 → EN1, EN1 seeing 00 → IDLE).
- Unchanged pattern: state holds.
- Any other pattern change (both bits toggling at once, e.g. EN1 seeing 01) → WAIT_CLR and `err` pulses.
- WAIT_CLR holds until `{a,b}` = 00, then goes to IDLE with no event.
- EN3 seeing 00 → IDLE with `enter` pulse. EX3 seeing 00 → IDLE with `exit` pulse.
- Counter on `enter`: increment unless `count == CAPACITY`, in which case it holds; the `enter` pulse is still emitted.
- Counter on `exit`: decrement unless `count == 0`, in which case it holds (no wrap to all-ones); the `exit` pulse is still emitted.
- `enter` and `exit` are mutually exclusive by construction and are never both high.
- `full`/`empty` are decoded from the `count` register.

## Timing
- All state, pulses and `count` are registered.
- Latency is 1 cycle: the edge that samples the completing pattern sets the pulse and updates `count` together.
- Pulses are exactly one cycle wide. Back-to-back cars give pulses at least 4 cycles apart.
- Reset (asynchronous assert, synchronous release), values held while `reset_n` = 0:
  - state = IDLE.
  - `count` = 0, `empty` = 1, `full` = 0.
  - `enter`/`exit`/`err` = 0.
  - `err_cnt` = 0.
- Reset mid-sequence discards the partial car and emits no event.
- First edge after release: `{a,b}` is evaluated from IDLE, so 11 gives `err` and enters WAIT_CLR.

## Configuration
- `LOT_ERR_CNT_EN` defined: `err_cnt[7:0]` port exists. It increments on every `err` pulse, saturates at 255, and is cleared only by reset.
- Not defined: the port and its register are absent. `err` pulse behaviour is identical in both builds.

## Test plan
- Reset, then drive `{a,b}` = 00,10,11,01,00 holding 3 cycles each → one `enter` pulse, `count` 0→1, `empty` 1→0.
- With `count` = 1, drive 00,01,11,10,00 → one `exit` pulse, `count` = 0, `empty` = 1. Then a second exit sequence → `exit` pulses, `count` stays 0.
- With `CAPACITY` = 15, perform 16 entries → `full` rises after the 15th; the 16th gives an `enter` pulse with `count` held at 15.
- Drive 00,10,11,10,00 (backout) → no `enter`/`exit`/`err`, `count` unchanged.
- Drive 00,10,01,11,00 → `err` pulses on the 01 sample, no events until 00, then a normal entry works. With `LOT_ERR_CNT_EN`, `err_cnt` = 1.
- Assert `reset_n` = 0 while in EN2 with `count` = 5 → `count` = 0 immediately; after release with `{a,b}` = 00, no pulses occur.

Source files
------------

// File: rtl/parking_lot_tracker.sv
// -----------------------------------------------------------------------------
// parking_lot_tracker
//
// Decodes the ordered blocking pattern of the two debounced gate sensors into
// single-cycle enter/exit events and keeps a saturating occupancy count.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset (synchronous release upstream)
//   a        - debounced outer sensor, 1 = beam blocked
//   b        - debounced inner sensor, 1 = beam blocked
//   enter    - one-cycle pulse on a completed entry
//   exit     - one-cycle pulse on a completed exit
//   err      - one-cycle pulse on an illegal sensor transition
//   count    - current occupancy (CNT_W bits, saturates at 0 and CAPACITY)
//   full     - count == CAPACITY
//   empty    - count == 0
//   err_cnt  - 8-bit saturating illegal-sequence count, only when the
//              LOT_ERR_CNT_EN macro is defined
//
// Parameters:
//   CNT_W    - occupancy counter width
//   CAPACITY - lot capacity, 1 <= CAPACITY <= 2**CNT_W - 1
// -----------------------------------------------------------------------------
module parking_lot_tracker #(
  parameter int CNT_W    = 4,
  parameter int CAPACITY = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  output logic             enter,
  output logic             exit,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef LOT_ERR_CNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EN1      = 3'd1,
    EN2      = 3'd2,
    EN3      = 3'd3,
    EX1      = 3'd4,
    EX2      = 3'd5,
    EX3      = 3'd6,
    WAIT_CLR = 3'd7
  } state_t;

  state_t           state_reg, state_next;
  logic             enter_reg, enter_next;
  logic             exit_reg, exit_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [1:0]       ab;

  assign ab = {a, b};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Each step state accepts its own pattern (hold), the
  // pattern of the neighbouring step forward or backward, and treats the
  // remaining pattern (both bits toggling) as an error.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        case (ab)
          2'b10:   state_next = EN1;
          2'b01:   state_next = EX1;
          2'b11:   state_next = WAIT_CLR;
          default: state_next = IDLE;
        endcase
      end
      EN1: begin
        case (ab)
          2'b00:   state_next = IDLE;
          2'b11:   state_next = EN2;
          2'b01:   state_next = WAIT_CLR;
          default: state_next = EN1;
        endcase
      end
      EN2: begin
        case (ab)
          2'b10:   state_next = EN1;
          2'b01:   state_next = EN3;
          2'b00:   state_next = WAIT_CLR;
          default: state_next = EN2;
        endcase
      end
      EN3: begin
        case (ab)
          2'b11:   state_next = EN2;
          2'b00:   state_next = IDLE;
          2'b10:   state_next = WAIT_CLR;
          default: state_next = EN3;
        endcase
      end
      EX1: begin
        case (ab)
          2'b00:   state_next = IDLE;
          2'b11:   state_next = EX2;
          2'b10:   state_next = WAIT_CLR;
          default: state_next = EX1;
        endcase
      end
      EX2: begin
        case (ab)
          2'b01:   state_next = EX1;
          2'b10:   state_next = EX3;
          2'b00:   state_next = WAIT_CLR;
          default: state_next = EX2;
        endcase
      end
      EX3: begin
        case (ab)
          2'b11:   state_next = EX2;
          2'b00:   state_next = IDLE;
          2'b01:   state_next = WAIT_CLR;
          default: state_next = EX3;
        endcase
      end
      default: begin // WAIT_CLR
        if (ab == 2'b00) state_next = IDLE;
      end
    endcase
  end

  // Output decode: pulses are computed here and registered below so they
  // appear on the same edge that takes the FSM to its next state.
  always_comb begin
    enter_next = 1'b0;
    exit_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: err_next   = (ab == 2'b11);
      EN1:  err_next   = (ab == 2'b01);
      EN2:  err_next   = (ab == 2'b00);
      EN3: begin
        enter_next = (ab == 2'b00);
        err_next   = (ab == 2'b10);
      end
      EX1:  err_next   = (ab == 2'b10);
      EX2:  err_next   = (ab == 2'b00);
      EX3: begin
        exit_next  = (ab == 2'b00);
        err_next   = (ab == 2'b01);
      end
      default: ; // WAIT_CLR never flags a second error
    endcase
  end

  // Occupancy update; saturates at both ends while still letting the
  // event pulse through.
  always_comb begin
    count_next = count_reg;
    if (enter_next && (count_reg != CAP)) begin
      count_next = count_reg + 1'b1;
    end else if (exit_next && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter_reg <= 1'b0;
      exit_reg  <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      enter_reg <= enter_next;
      exit_reg  <= exit_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

`ifdef LOT_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_reg <= 8'd0;
    end else if (err_next && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

  assign enter = enter_reg;
  assign exit  = exit_reg;
  assign err   = err_reg;
  assign count = count_reg;
  assign full  = (count_reg == CAP);
  assign empty = (count_reg == '0);

endmodule

// File: tb/tb_parking_lot_tracker.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_tracker
//
// Directed, table-driven bench for parking_lot_tracker (CNT_W=4, CAPACITY=15).
// Each table record drives one {a,b} pattern for n cycles; the expected pulses
// apply to the first cycle only, the expected count to every cycle. Capacity
// saturation, mid-sequence reset and first-edge-after-reset are hand-written.
// -----------------------------------------------------------------------------
module tb_parking_lot_tracker;

  localparam int CNT_W    = 4;
  localparam int CAPACITY = 15;

  logic             clk;
  logic             reset_n;
  logic             a;
  logic             b;
  logic             enter;
  logic             exit;
  logic             err;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
`ifdef LOT_ERR_CNT_EN
  logic [7:0]       err_cnt;
  int               exp_err_cnt;
`endif

  int tests;
  int fails;

  parking_lot_tracker #(
    .CNT_W    (CNT_W),
    .CAPACITY (CAPACITY)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .enter   (enter),
    .exit    (exit),
    .err     (err),
    .count   (count),
    .full    (full),
    .empty   (empty)
`ifdef LOT_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ab;
    int         n;
    logic       en;
    logic       ex;
    logic       er;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] ab, input int n, input logic en,
                     input logic ex, input logic er, input int cnt);
    vec_t v;
    v.ab = ab; v.n = n; v.en = en; v.ex = ex; v.er = er; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic ex,
                            input logic er, input int cnt);
    check({tag, " enter"}, int'(enter), int'(en));
    check({tag, " exit"},  int'(exit),  int'(ex));
    check({tag, " err"},   int'(err),   int'(er));
    check({tag, " count"}, int'(count), cnt);
    check({tag, " full"},  int'(full),  (cnt == CAPACITY) ? 1 : 0);
    check({tag, " empty"}, int'(empty), (cnt == 0) ? 1 : 0);
  endtask

  // Drive one pattern for a cycle and sample 1 time unit after the edge.
  task automatic cyc(input logic [1:0] ab);
    @(negedge clk);
    {a, b} = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] ab_at_release);
    @(negedge clk);
    reset_n = 1'b0;
    {a, b} = 2'b00;
    repeat (2) @(negedge clk);
    {a, b} = ab_at_release;
    reset_n = 1'b1;
`ifdef LOT_ERR_CNT_EN
    exp_err_cnt = 0;
`endif
  endtask

  task automatic car_in(input string tag, input int exp_cnt);
    cyc(2'b10); cyc(2'b11); cyc(2'b01);
    cyc(2'b00);
    check_outs(tag, 1'b1, 1'b0, 1'b0, exp_cnt);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    a       = 1'b0;
    b       = 1'b0;
`ifdef LOT_ERR_CNT_EN
    exp_err_cnt = 0;
`endif

    // Reset state while held
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
`ifdef LOT_ERR_CNT_EN
    check("reset err_cnt", int'(err_cnt), 0);
`endif

    // ab, cycles, enter, exit, err (first cycle), count
    // Entry with 3-cycle holds
    add(2'b00, 3, 0, 0, 0, 0);
    add(2'b10, 3, 0, 0, 0, 0);
    add(2'b11, 3, 0, 0, 0, 0);
    add(2'b01, 3, 0, 0, 0, 0);
    add(2'b00, 3, 1, 0, 0, 1);
    // Exit
    add(2'b01, 3, 0, 0, 0, 1);
    add(2'b11, 3, 0, 0, 0, 1);
    add(2'b10, 3, 0, 0, 0, 1);
    add(2'b00, 3, 0, 1, 0, 0);
    // Exit at empty: pulse, count stays 0
    add(2'b01, 2, 0, 0, 0, 0);
    add(2'b11, 2, 0, 0, 0, 0);
    add(2'b10, 2, 0, 0, 0, 0);
    add(2'b00, 2, 0, 1, 0, 0);
    // Entry backout
    add(2'b10, 2, 0, 0, 0, 0);
    add(2'b11, 2, 0, 0, 0, 0);
    add(2'b10, 2, 0, 0, 0, 0);
    add(2'b00, 2, 0, 0, 0, 0);
    // Exit backout from EX2 and partial back from EN3
    add(2'b01, 1, 0, 0, 0, 0);
    add(2'b11, 1, 0, 0, 0, 0);
    add(2'b01, 1, 0, 0, 0, 0);
    add(2'b00, 1, 0, 0, 0, 0);
    add(2'b10, 1, 0, 0, 0, 0);
    add(2'b11, 1, 0, 0, 0, 0);
    add(2'b01, 1, 0, 0, 0, 0);
    add(2'b11, 1, 0, 0, 0, 0);
    add(2'b10, 1, 0, 0, 0, 0);
    add(2'b00, 1, 0, 0, 0, 0);
    // Illegal jump EN1 -> 01, wait for clear, then a normal entry
    add(2'b10, 2, 0, 0, 0, 0);
    add(2'b01, 2, 0, 0, 1, 0);
    add(2'b11, 2, 0, 0, 0, 0);
    add(2'b00, 2, 0, 0, 0, 0);
    add(2'b10, 1, 0, 0, 0, 0);
    add(2'b11, 1, 0, 0, 0, 0);
    add(2'b01, 1, 0, 0, 0, 0);
    add(2'b00, 1, 1, 0, 0, 1);
    // 11 from IDLE is an error; no second error while in WAIT_CLR
    add(2'b11, 2, 0, 0, 1, 1);
    add(2'b10, 1, 0, 0, 0, 1);
    add(2'b01, 1, 0, 0, 0, 1);
    add(2'b00, 1, 0, 0, 0, 1);
    // Illegal jump EX2 -> 00
    add(2'b01, 1, 0, 0, 0, 1);
    add(2'b11, 1, 0, 0, 0, 1);
    add(2'b00, 2, 0, 0, 1, 1);
    // Illegal jump EX3 -> 01
    add(2'b01, 1, 0, 0, 0, 1);
    add(2'b11, 1, 0, 0, 0, 1);
    add(2'b10, 1, 0, 0, 0, 1);
    add(2'b01, 1, 0, 0, 1, 1);
    add(2'b00, 1, 0, 0, 0, 1);

    do_reset(2'b00);
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        cyc(vecs[i].ab);
`ifdef LOT_ERR_CNT_EN
        if (k == 0 && vecs[i].er) exp_err_cnt++;
`endif
        if (k == 0)
          check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].ex,
                     vecs[i].er, vecs[i].cnt);
        else
          check_outs($sformatf("vec%0d.%0d", i, k), 1'b0, 1'b0, 1'b0,
                     vecs[i].cnt);
      end
      $display("[TB] vector %0d ab=%b x%0d count=%0d", i, vecs[i].ab,
               vecs[i].n, count);
    end
`ifdef LOT_ERR_CNT_EN
    check("table err_cnt", int'(err_cnt), exp_err_cnt);
`endif

    // Capacity saturation: 16 entries from empty
    do_reset(2'b00);
    for (int i = 1; i <= 16; i++) begin
      car_in($sformatf("cap%0d", i), (i > CAPACITY) ? CAPACITY : i);
      $display("[TB] entry %0d count=%0d full=%0b", i, count, full);
    end
    cyc(2'b00);
    check_outs("cap hold", 1'b0, 1'b0, 1'b0, CAPACITY);

    // Reset while in EN2 with count 5
    do_reset(2'b00);
    for (int i = 1; i <= 5; i++) car_in($sformatf("pre%0d", i), i);
    cyc(2'b10);
    cyc(2'b11);
    check_outs("en2", 1'b0, 1'b0, 1'b0, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async rst", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    {a, b} = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(2'b00);
      check_outs($sformatf("post rst%0d", k), 1'b0, 1'b0, 1'b0, 0);
    end
    $display("[TB] mid-sequence reset count=%0d", count);

    // First edge after release with 11 -> error from IDLE
    do_reset(2'b11);
    @(posedge clk);
    #1;
    check_outs("rel 11", 1'b0, 1'b0, 1'b1, 0);
    cyc(2'b00);
    check_outs("rel clr", 1'b0, 1'b0, 1'b0, 0);
    car_in("rel entry", 1);
`ifdef LOT_ERR_CNT_EN
    check("rel err_cnt", int'(err_cnt), 1);
`endif
    $display("[TB] release-with-11 sequence count=%0d", count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
